ws2812_frame_streamer: RTL

- Parametrised WS2812B-class serial LED driver that streams a whole frame of NUM_PIXELS pixels, each BPP bits, MSB-first, on a single data line.
- Pixels arrive one at a time over a valid/ready handshake from an upstream frame source, such as a face/colour mapper or framebuffer reader.
- Bit timings and latch length are cycle-count parameters, so the block retargets to any clock without RTL edits.
- Adds frame start/done control, a stall watchdog and an underrun flag.

---
 rtl/ws2812_frame_streamer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ws2812_frame_streamer.sv
// WS2812B-class frame streamer: accepts NUM_PIXELS words over valid/ready and serialises them MSB-first with cycle-count bit timing.
// Define WS2812_BRIGHTNESS_EN to add an 8-bit brightness port that scales every channel when a pixel is loaded.
module ws2812_frame_streamer #(
    parameter int NUM_PIXELS = 64,
    parameter int BPP        = 24,
    parameter int T0H_CYC    = 16,
    parameter int T1H_CYC    = 32,
    parameter int T0L_CYC    = 34,
    parameter int T1L_CYC    = 18,
    parameter int RESET_CYC  = 2000,
    parameter int STALL_CYC  = 200
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [BPP-1:0] pix_data,
    input  logic           pix_valid,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]     brightness,
`endif
    output logic           pix_ready,
    output logic           dout,
    output logic           busy,
    output logic           frame_done,
    output logic           underrun
);

    localparam int MAX_H = (T1H_CYC > T0H_CYC) ? T1H_CYC : T0H_CYC;
    localparam int MAX_L = (T1L_CYC > T0L_CYC) ? T1L_CYC : T0L_CYC;
    localparam int MAX_B = (MAX_H > MAX_L) ? MAX_H : MAX_L;
    localparam int MAX_T = (MAX_B > RESET_CYC) ? MAX_B : RESET_CYC;
    localparam int PH_W  = $clog2(MAX_T + 1);
    localparam int PC_W  = $clog2(NUM_PIXELS + 1);
    localparam int BC_W  = $clog2(BPP);
    localparam int ST_W  = $clog2(STALL_CYC + 1);

    localparam logic [PH_W-1:0] T0H_M1   = PH_W'(T0H_CYC - 1);
    localparam logic [PH_W-1:0] T1H_M1   = PH_W'(T1H_CYC - 1);
    localparam logic [PH_W-1:0] T0L_M1   = PH_W'(T0L_CYC - 1);
    localparam logic [PH_W-1:0] T1L_M1   = PH_W'(T1L_CYC - 1);
    localparam logic [PH_W-1:0] RST_M1   = PH_W'(RESET_CYC - 1);
    localparam logic [ST_W-1:0] STALL_M1 = ST_W'(STALL_CYC - 1);
    localparam logic [PC_W-1:0] NPIX     = PC_W'(NUM_PIXELS);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(BPP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HIGH,
        S_LOW,
        S_LATCH
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [ST_W-1:0] stall_q, stall_d;
    logic [PC_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BPP-1:0]  shreg_q, shreg_d;
    logic            abort_q, abort_d;
    logic            done_q, done_d;
    logic            unr_q, unr_d;
    logic            dout_q;
    logic [BPP-1:0]  load_dat;
    logic [PH_W-1:0] hi_m1, lo_m1;

`ifdef WS2812_BRIGHTNESS_EN
    // Scale each 8-bit channel by (brightness+1)/256; 255 leaves the pixel untouched.
    always_comb begin
        load_dat = '0;
        for (int c = 0; c < BPP / 8; c++) begin
            load_dat[c*8 +: 8] = 8'(({8'd0, pix_data[c*8 +: 8]} * ({8'd0, brightness} + 16'd1)) >> 8);
        end
    end
`else
    assign load_dat = pix_data;
`endif

    assign hi_m1 = shreg_q[BPP-1] ? T1H_M1 : T0H_M1;
    assign lo_m1 = shreg_q[BPP-1] ? T1L_M1 : T0L_M1;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        stall_d   = stall_q;
        pix_cnt_d = pix_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        abort_d   = abort_q;
        done_d    = 1'b0;
        unr_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    pix_cnt_d = '0;
                    stall_d   = '0;
                    phase_d   = '0;
                    abort_d   = 1'b0;
                end
            end
            S_FETCH: begin
                if (pix_valid) begin
                    shreg_d   = load_dat;
                    bit_cnt_d = LAST_BIT;
                    pix_cnt_d = pix_cnt_q + PC_W'(1);
                    stall_d   = '0;
                    phase_d   = '0;
                    state_d   = S_HIGH;
                end else if (pix_cnt_q != '0) begin
                    // Only pixels after the first are watched; the first may wait forever.
                    if (stall_q == STALL_M1) begin
                        state_d = S_LATCH;
                        phase_d = '0;
                        unr_d   = 1'b1;
                        abort_d = 1'b1;
                    end else begin
                        stall_d = stall_q + ST_W'(1);
                    end
                end
            end
            S_HIGH: begin
                if (phase_q == hi_m1) begin
                    phase_d = '0;
                    state_d = S_LOW;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_LOW: begin
                if (phase_q == lo_m1) begin
                    phase_d = '0;
                    if (bit_cnt_q != '0) begin
                        shreg_d   = {shreg_q[BPP-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - BC_W'(1);
                        state_d   = S_HIGH;
                    end else if (pix_cnt_q < NPIX) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_LATCH;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_LATCH: begin
                if (phase_q == RST_M1) begin
                    phase_d = '0;
                    state_d = S_IDLE;
                    done_d  = ~abort_q;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            stall_q   <= '0;
            pix_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            unr_q     <= 1'b0;
            dout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            stall_q   <= stall_d;
            pix_cnt_q <= pix_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            abort_q   <= abort_d;
            done_q    <= done_d;
            unr_q     <= unr_d;
            // Registered from next state so dout tracks the HIGH phase exactly with no decode glitches.
            dout_q    <= (state_d == S_HIGH);
        end
    end

    assign pix_ready  = (state_q == S_FETCH);
    assign busy       = (state_q != S_IDLE);
    assign dout       = dout_q;
    assign frame_done = done_q;
    assign underrun   = unr_q;

endmodule
